data_back_serializer: RTL and testbench

- Transmit-side stage that drains 160-bit result words from the data-back FIFO and serialises each into a UART byte stream.
- Sits between the 160-bit data-back FIFO (standard read, 1-cycle dout latency) and the UART transmitter byte interface.
- Each word goes out as: header byte, 20 data bytes MSB-first, and an optional checksum byte.

---
 rtl/data_back_pkg.sv | 34 +++
 rtl/data_back_serializer_if.sv | 31 +++
 rtl/data_back_serializer_handshake.sv | 62 ++++++
 rtl/data_back_serializer.sv | 133 +++++++++++++
 tb/tb_data_back_serializer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_back_pkg.sv
// -----------------------------------------------------------------------------
// data_back_pkg
// Shared definitions for the data-back serializer: framing FSM state encoding,
// datapath widths, default header byte and the frame length.
// Build option: DATA_BACK_CHECKSUM_EN appends an XOR checksum byte to every
// frame. This changes the frame length from 21 bytes to 22 bytes.
// -----------------------------------------------------------------------------
package data_back_pkg;

   localparam int DATA_W         = 160;
   localparam int BYTE_W         = 8;
   localparam int NUM_DATA_BYTES = DATA_W / BYTE_W;

   localparam logic [BYTE_W-1:0] DEFAULT_HEADER_BYTE = 8'hA5;

   // A frame is the header byte followed by the data bytes, plus an
   // optional checksum byte at the end.
`ifdef DATA_BACK_CHECKSUM_EN
   localparam int FRAME_LEN = NUM_DATA_BYTES + 2;
`else
   localparam int FRAME_LEN = NUM_DATA_BYTES + 1;
`endif
   localparam int LAST_IDX = FRAME_LEN - 1;
   localparam int CNT_W    = $clog2(FRAME_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_DONE
   } state_e;

endpackage

// File: rtl/data_back_serializer_if.sv
// -----------------------------------------------------------------------------
// data_back_serializer_if
// Bundles the serializer's FIFO read port and its UART byte port.
//   data_back_fifo_empty : FIFO empty flag
//   data_back_fifo_rd    : FIFO read strobe (one-cycle pulse)
//   data_back            : FIFO dout, valid the cycle after the read strobe
//   send_ready           : UART idle / able to accept a byte
//   start_send           : byte request to the UART
//   data_send            : byte to transmit
// Modports: master = serializer side, slave = FIFO/UART side.
// -----------------------------------------------------------------------------
interface data_back_serializer_if;

   logic                              data_back_fifo_empty;
   logic                              data_back_fifo_rd;
   logic [data_back_pkg::DATA_W-1:0]  data_back;
   logic                              send_ready;
   logic                              start_send;
   logic [data_back_pkg::BYTE_W-1:0]  data_send;

   modport master (
      input  data_back_fifo_empty, data_back, send_ready,
      output data_back_fifo_rd, start_send, data_send
   );

   modport slave (
      output data_back_fifo_empty, data_back, send_ready,
      input  data_back_fifo_rd, start_send, data_send
   );

endinterface

// File: rtl/data_back_serializer_handshake.sv
// -----------------------------------------------------------------------------
// uart_byte_handshake
// Request/accept/done sequencing for one byte towards the UART, and the
// per-phase timeout counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   send_phase   : framer is in SEND (request phase)
//   wait_phase   : framer is in WAIT_DONE (byte in flight)
//   send_ready   : UART idle flag
//   byte_valid   : request towards the UART (drives start_send)
//   byte_accept  : UART took the byte (send_ready seen low after request)
//   byte_done    : UART finished the byte (send_ready seen high again)
//   timeout      : the current phase has lasted ACK_TIMEOUT cycles
// ACK_TIMEOUT = 0 disables the timeout.
// -----------------------------------------------------------------------------
module uart_byte_handshake #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic send_phase,
   input  logic wait_phase,
   input  logic send_ready,
   output logic byte_valid,
   output logic byte_accept,
   output logic byte_done,
   output logic timeout
);

   localparam logic [7:0] TO_LAST = (ACK_TIMEOUT > 0) ? 8'(ACK_TIMEOUT - 1) : 8'd0;

   logic       req_driven;
   logic [7:0] phase_cnt;
   logic       progress;

   assign byte_valid  = send_phase;
   // A send_ready that is already low on the first SEND cycle is not an
   // accept. The request must first have been driven for one full cycle.
   assign byte_accept = send_phase && req_driven && !send_ready;
   assign byte_done   = wait_phase && send_ready;
   assign progress    = byte_accept || byte_done;
   // A phase that makes progress in its last allowed cycle does not time out.
   assign timeout     = (ACK_TIMEOUT != 0) && (send_phase || wait_phase) &&
                        !progress && (phase_cnt == TO_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_driven <= 1'b0;
         phase_cnt  <= '0;
      end else begin
         req_driven <= send_phase;
         // Any phase change (progress, or leaving both phases) restarts the
         // count, so every entry into SEND or WAIT_DONE begins at zero.
         if (!(send_phase || wait_phase) || progress)
            phase_cnt <= '0;
         else
            phase_cnt <= phase_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/data_back_serializer.sv
// -----------------------------------------------------------------------------
// data_back_serializer
// Reads 160-bit words from the data-back FIFO and sends each one to the UART
// as a frame: HEADER_BYTE, then data_back[159:152] .. data_back[7:0].
// With DATA_BACK_CHECKSUM_EN defined, an XOR-of-data checksum byte follows
// the data bytes.
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus (master)     : FIFO read port and UART byte port
//   busy             : state is not IDLE
//   frames_sent      : completed frames, wraps at 16 bits
//   ack_timeout_err  : sticky handshake timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module data_back_serializer
   import data_back_pkg::*;
#(
   parameter logic [BYTE_W-1:0] HEADER_BYTE = DEFAULT_HEADER_BYTE,
   parameter int                ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   data_back_serializer_if.master bus,
   output logic                  busy,
   output logic [15:0]           frames_sent,
   output logic                  ack_timeout_err
);

   state_e             state, state_next;
   logic [DATA_W-1:0]  shift_reg;
   logic [CNT_W-1:0]   byte_cnt;
   logic [BYTE_W-1:0]  data_send_q;
   logic [BYTE_W-1:0]  next_data;
   logic               last_byte;
   logic               send_phase, wait_phase;
   logic               byte_valid, byte_accept, byte_done, timeout;
`ifdef DATA_BACK_CHECKSUM_EN
   logic [BYTE_W-1:0]  checksum;
`endif

   assign send_phase = (state == ST_SEND);
   assign wait_phase = (state == ST_WAIT_DONE);
   assign last_byte  = (byte_cnt == CNT_W'(LAST_IDX));

   uart_byte_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_handshake (
      .clk         (clk),
      .reset_n     (reset_n),
      .send_phase  (send_phase),
      .wait_phase  (wait_phase),
      .send_ready  (bus.send_ready),
      .byte_valid  (byte_valid),
      .byte_accept (byte_accept),
      .byte_done   (byte_done),
      .timeout     (timeout)
   );

   // Decoding outputs from the state register means an asynchronous reset
   // drops the read strobe and the byte request immediately.
   assign bus.data_back_fifo_rd = (state == ST_FETCH);
   assign bus.start_send        = byte_valid;
   assign bus.data_send         = data_send_q;
   assign busy                  = (state != ST_IDLE);

   // Just after the header, the first data byte is still at the top of the
   // shift register. After that, each advance shifts out one byte first.
   assign next_data = (byte_cnt == '0) ? shift_reg[DATA_W-1 -: BYTE_W]
                                       : shift_reg[DATA_W-BYTE_W-1 -: BYTE_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // NOTE: state_next gets a default before the case statement, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:      if (!bus.data_back_fifo_empty) state_next = ST_FETCH;
         ST_FETCH:     state_next = ST_LOAD;
         ST_LOAD:      state_next = ST_SEND;
         ST_SEND: begin
            if (timeout)          state_next = ST_IDLE;
            else if (byte_accept) state_next = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (timeout)          state_next = ST_IDLE;
            else if (byte_done)   state_next = last_byte ? ST_IDLE : ST_SEND;
         end
         default:      state_next = ST_IDLE;
      endcase
   end

   // NOTE: the 160-bit shift register is reset along with the control state,
   // so the register contents always have a defined value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg       <= '0;
         byte_cnt        <= '0;
         data_send_q     <= '0;
         frames_sent     <= '0;
         ack_timeout_err <= 1'b0;
`ifdef DATA_BACK_CHECKSUM_EN
         checksum        <= '0;
`endif
      end else begin
         if (state == ST_LOAD) begin
            shift_reg   <= bus.data_back;
            byte_cnt    <= '0;
            data_send_q <= HEADER_BYTE;
`ifdef DATA_BACK_CHECKSUM_EN
            checksum    <= '0;
`endif
         end else if (byte_done && !last_byte) begin
            byte_cnt <= byte_cnt + 1'b1;
`ifdef DATA_BACK_CHECKSUM_EN
            if (byte_cnt == CNT_W'(NUM_DATA_BYTES)) begin
               data_send_q <= checksum;
            end else begin
               data_send_q <= next_data;
               checksum    <= checksum ^ next_data;
               if (byte_cnt != '0) shift_reg <= shift_reg << BYTE_W;
            end
`else
            data_send_q <= next_data;
            if (byte_cnt != '0) shift_reg <= shift_reg << BYTE_W;
`endif
         end

         if (byte_done && last_byte) frames_sent <= frames_sent + 16'd1;
         if (timeout)                ack_timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_back_serializer.sv
// -----------------------------------------------------------------------------
// tb_data_back_serializer
// Self-checking bench for data_back_serializer. It has a FIFO model, a UART
// model and a scoreboard that holds the expected byte stream.
// -----------------------------------------------------------------------------
module tb_data_back_serializer;
   import data_back_pkg::*;

`ifdef DATA_BACK_CHECKSUM_EN
   localparam int EXP_FRAME_LEN = 22;
`else
   localparam int EXP_FRAME_LEN = 21;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   data_back_serializer_if bus();
   logic        busy;
   logic [15:0] frames_sent;
   logic        ack_timeout_err;

   data_back_serializer #(.HEADER_BYTE(8'hA5), .ACK_TIMEOUT(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .bus             (bus),
      .busy            (busy),
      .frames_sent     (frames_sent),
      .ack_timeout_err (ack_timeout_err)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // ---------------- FIFO model (standard read, 1-cycle dout) ---------------
   logic [DATA_W-1:0] fifo_mem [0:15];
   int fifo_wr = 0;
   int fifo_rd = 0;
   assign bus.data_back_fifo_empty = (fifo_wr == fifo_rd);
   always @(posedge clk) begin
      if (bus.data_back_fifo_rd && (fifo_wr != fifo_rd)) begin
         bus.data_back <= fifo_mem[fifo_rd % 16];
         fifo_rd       <= fifo_rd + 1;
      end
   end

   // ---------------- UART model: accept after 3, done after 10 --------------
   typedef enum {U_IDLE, U_ACC, U_BUSY} uart_e;
   uart_e      ust;
   int         ucnt;
   logic       uart_stuck = 1'b0;
   logic [7:0] rx_mem [0:255];
   int         rx_wr = 0;
   logic [7:0] cap;
   int         unstable = 0;
   int         last_done_cyc = -1000;
   int         cyc = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ust            <= U_IDLE;
         ucnt           <= 0;
         bus.send_ready <= 1'b1;
      end else begin
         case (ust)
            U_IDLE: if (bus.start_send && !uart_stuck) begin
               ust  <= U_ACC;
               ucnt <= 0;
            end
            U_ACC: if (ucnt == 2) begin
               bus.send_ready <= 1'b0;
               cap            <= bus.data_send;
               rx_mem[rx_wr]  <= bus.data_send;
               rx_wr          <= rx_wr + 1;
               ust            <= U_BUSY;
               ucnt           <= 0;
            end else begin
               ucnt <= ucnt + 1;
            end
            U_BUSY: begin
               if (bus.data_send !== cap) unstable <= unstable + 1;
               if (ucnt == 9) begin
                  bus.send_ready <= 1'b1;
                  ust            <= U_IDLE;
                  // The DUT samples the raised send_ready on the next edge.
                  last_done_cyc  <= cyc + 1;
               end else begin
                  ucnt <= ucnt + 1;
               end
            end
            default: ust <= U_IDLE;
         endcase
      end
   end

   // ---------------- Read-strobe / request monitor --------------------------
   int   rd_pulses    = 0;
   int   rd_bad       = 0;
   int   start_cycles = 0;
   int   gap_mem [0:63];
   logic rd_prev      = 1'b0;
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_prev <= bus.data_back_fifo_rd;
      if (bus.data_back_fifo_rd) begin
         rd_pulses <= rd_pulses + 1;
         if (rd_pulses < 64) gap_mem[rd_pulses] <= cyc - last_done_cyc;
         if (bus.data_back_fifo_empty || rd_prev) rd_bad <= rd_bad + 1;
      end
      if (bus.start_send) start_cycles <= start_cycles + 1;
   end

   // ---------------- Scoreboard ---------------------------------------------
   logic [7:0] exp_q [$];
   int         rx_rd = 0;

   task automatic push_word(input logic [DATA_W-1:0] w, input bit expect_frame);
      logic [7:0] b, x;
      fifo_mem[fifo_wr % 16] = w;
      fifo_wr++;
      if (expect_frame) begin
         x = 8'h00;
         exp_q.push_back(8'hA5);
         for (int i = 0; i < 20; i++) begin
            b = w[159 - 8*i -: 8];
            x = x ^ b;
            exp_q.push_back(b);
         end
`ifdef DATA_BACK_CHECKSUM_EN
         exp_q.push_back(x);
`endif
      end
   endtask

   task automatic wait_frames(input logic [15:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (frames_sent == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- Tests --------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (bus.start_send !== 1'b0) $display("FAIL reset start_send: got %b want 0", bus.start_send); else pass_cnt++;
      total_cnt++; if (bus.data_back_fifo_rd !== 1'b0) $display("FAIL reset fifo_rd: got %b want 0", bus.data_back_fifo_rd); else pass_cnt++;
      total_cnt++; if (bus.data_send !== 8'h00) $display("FAIL reset data_send: got %h want 00", bus.data_send); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (frames_sent !== 16'd0) $display("FAIL reset frames_sent: got %0d want 0", frames_sent); else pass_cnt++;
      total_cnt++; if (ack_timeout_err !== 1'b0) $display("FAIL reset ack_timeout_err: got %b want 0", ack_timeout_err); else pass_cnt++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_empty();
      int r0, s0, busy_cnt;
      r0 = rd_pulses; s0 = start_cycles; busy_cnt = 0;
      repeat (1000) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      total_cnt++; if (rd_pulses - r0 !== 0) $display("FAIL idle fifo_rd pulses: got %0d want 0", rd_pulses - r0); else pass_cnt++;
      total_cnt++; if (start_cycles - s0 !== 0) $display("FAIL idle start_send cycles: got %0d want 0", start_cycles - s0); else pass_cnt++;
      total_cnt++; if (busy_cnt !== 0) $display("FAIL idle busy cycles: got %0d want 0", busy_cnt); else pass_cnt++;
   endtask

   task automatic test_single_word();
      logic [DATA_W-1:0] w;
      logic [15:0]       f0;
      logic [7:0]        exp_b;
      int                r0, b0;
      bit                ok;
      for (int i = 0; i < 20; i++) w[159 - 8*i -: 8] = 8'(i + 1);
      exp_q.delete();
      rx_rd = rx_wr; b0 = rx_wr; r0 = rd_pulses; f0 = frames_sent;
      push_word(w, 1'b1);
      wait_frames(f0 + 16'd1, 3000, ok);
      total_cnt++; if (!ok) $display("FAIL single frame completion: got frames_sent=%0d want %0d", frames_sent, f0 + 16'd1); else pass_cnt++;
      repeat (20) @(negedge clk);
      total_cnt++; if (rx_wr - b0 !== EXP_FRAME_LEN) $display("FAIL single byte count: got %0d want %0d", rx_wr - b0, EXP_FRAME_LEN); else pass_cnt++;
`ifdef DATA_BACK_CHECKSUM_EN
      total_cnt++; if (rx_mem[b0 + 21] !== 8'h14) $display("FAIL single checksum: got %h want 14", rx_mem[b0 + 21]); else pass_cnt++;
`endif
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         total_cnt++;
         if (rx_mem[rx_rd] !== exp_b) $display("FAIL single byte %0d: got %h want %h", rx_rd - b0, rx_mem[rx_rd], exp_b); else pass_cnt++;
         rx_rd++;
      end
      total_cnt++; if (rd_pulses - r0 !== 1) $display("FAIL single rd pulses: got %0d want 1", rd_pulses - r0); else pass_cnt++;
      total_cnt++; if (rd_bad !== 0) $display("FAIL single rd protocol errors: got %0d want 0", rd_bad); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL single busy after frame: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (unstable !== 0) $display("FAIL single data_send unstable: got %0d want 0", unstable); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] w;
      logic [15:0]       f0;
      logic [7:0]        exp_b;
      int                r0, b0;
      bit                ok;
      exp_q.delete();
      rx_rd = rx_wr; b0 = rx_wr; r0 = rd_pulses; f0 = frames_sent;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 5; j++) w[32*j +: 32] = $urandom;
         push_word(w, 1'b1);
      end
      wait_frames(f0 + 16'd3, 4000, ok);
      total_cnt++; if (!ok) $display("FAIL b2b frame completion: got frames_sent=%0d want %0d", frames_sent, f0 + 16'd3); else pass_cnt++;
      repeat (20) @(negedge clk);
      total_cnt++; if (rx_wr - b0 !== 3 * EXP_FRAME_LEN) $display("FAIL b2b byte count: got %0d want %0d", rx_wr - b0, 3 * EXP_FRAME_LEN); else pass_cnt++;
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         total_cnt++;
         if (rx_mem[rx_rd] !== exp_b) $display("FAIL b2b byte %0d: got %h want %h", rx_rd - b0, rx_mem[rx_rd], exp_b); else pass_cnt++;
         rx_rd++;
      end
      total_cnt++; if (rd_pulses - r0 !== 3) $display("FAIL b2b rd pulses: got %0d want 3", rd_pulses - r0); else pass_cnt++;
      for (int k = 1; k < 3; k++) begin
         total_cnt++;
         if (gap_mem[r0 + k] < 2) $display("FAIL b2b rd gap %0d: got %0d cycles want >=2", k, gap_mem[r0 + k]); else pass_cnt++;
      end
      total_cnt++; if (rd_bad !== 0) $display("FAIL b2b rd protocol errors: got %0d want 0", rd_bad); else pass_cnt++;
      total_cnt++; if (unstable !== 0) $display("FAIL b2b data_send unstable: got %0d want 0", unstable); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      logic [DATA_W-1:0] w;
      logic [7:0]        exp_b;
      int                b0, b1;
      bit                found, ok;
      exp_q.delete();
      rx_rd = rx_wr; b0 = rx_wr;
      for (int j = 0; j < 5; j++) w[32*j +: 32] = $urandom;
      push_word(w, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ((rx_wr - b0 >= 7) && bus.start_send) begin
            found = 1'b1;
            break;
         end
      end
      total_cnt++; if (!found) $display("FAIL midreset reach byte 7: got %0d bytes want 7 with request", rx_wr - b0); else pass_cnt++;
      reset_n = 1'b0;
      #1;
      total_cnt++; if (bus.start_send !== 1'b0) $display("FAIL midreset start_send: got %b want 0", bus.start_send); else pass_cnt++;
      total_cnt++; if (bus.data_back_fifo_rd !== 1'b0) $display("FAIL midreset fifo_rd: got %b want 0", bus.data_back_fifo_rd); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL midreset busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (bus.data_send !== 8'h00) $display("FAIL midreset data_send: got %h want 00", bus.data_send); else pass_cnt++;
      total_cnt++; if (frames_sent !== 16'd0) $display("FAIL midreset frames_sent: got %0d want 0", frames_sent); else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
         exp_b = exp_q.pop_front();
         total_cnt++;
         if (rx_mem[rx_rd] !== exp_b) $display("FAIL midreset partial byte %0d: got %h want %h", i, rx_mem[rx_rd], exp_b); else pass_cnt++;
         rx_rd++;
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rx_rd = rx_wr; b1 = rx_wr;
      for (int j = 0; j < 5; j++) w[32*j +: 32] = $urandom;
      push_word(w, 1'b1);
      wait_frames(16'd1, 3000, ok);
      total_cnt++; if (!ok) $display("FAIL midreset next frame completion: got frames_sent=%0d want 1", frames_sent); else pass_cnt++;
      repeat (20) @(negedge clk);
      total_cnt++; if (rx_wr - b1 !== EXP_FRAME_LEN) $display("FAIL midreset next byte count: got %0d want %0d", rx_wr - b1, EXP_FRAME_LEN); else pass_cnt++;
      total_cnt++; if (rx_mem[b1] !== 8'hA5) $display("FAIL midreset first byte: got %h want a5", rx_mem[b1]); else pass_cnt++;
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         total_cnt++;
         if (rx_mem[rx_rd] !== exp_b) $display("FAIL midreset next byte %0d: got %h want %h", rx_rd - b1, rx_mem[rx_rd], exp_b); else pass_cnt++;
         rx_rd++;
      end
   endtask

   task automatic test_timeout();
      logic [DATA_W-1:0] w;
      logic [15:0]       f0;
      int                n, b0;
      bit                found;
      uart_stuck = 1'b1;
      f0 = frames_sent; b0 = rx_wr;
      for (int j = 0; j < 5; j++) w[32*j +: 32] = $urandom;
      push_word(w, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.start_send) begin
            found = 1'b1;
            break;
         end
      end
      total_cnt++; if (!found) $display("FAIL timeout request seen: got start_send=%b want 1", bus.start_send); else pass_cnt++;
      n = 0;
      while (bus.start_send && n < 100) begin
         n++;
         @(negedge clk);
      end
      total_cnt++; if (n !== 16) $display("FAIL timeout SEND cycles: got %0d want 16", n); else pass_cnt++;
      total_cnt++; if (ack_timeout_err !== 1'b1) $display("FAIL timeout err flag: got %b want 1", ack_timeout_err); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL timeout busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (frames_sent !== f0) $display("FAIL timeout frames_sent: got %0d want %0d", frames_sent, f0); else pass_cnt++;
      repeat (10) @(negedge clk);
      total_cnt++; if (ack_timeout_err !== 1'b1) $display("FAIL timeout err sticky: got %b want 1", ack_timeout_err); else pass_cnt++;
      total_cnt++; if (rx_wr - b0 !== 0) $display("FAIL timeout bytes accepted: got %0d want 0", rx_wr - b0); else pass_cnt++;
      uart_stuck = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++; if (ack_timeout_err !== 1'b0) $display("FAIL timeout err after reset: got %b want 0", ack_timeout_err); else pass_cnt++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_idle_empty();
      test_single_word();
      test_back_to_back();
      test_reset_mid_frame();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion want finish before 60000 cycles");
      $fatal(1);
   end

endmodule
